multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It fetches one instruction at a time over a ready-gated instruction port and holds it in the instruction register. The register output ir_q drives the immediate generator and the register-file address fields. The FSM then steps each instruction through DECODE/EXEC/MEM/WB, driving datapath selects and write strobes, and counts retired instructions.

---
 rtl/riscv_ctrl_pkg.sv | 59 +++++
 rtl/ctrl_decode.sv | 30 +++
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes (also
// used by the immediate generator), FSM states, instruction classes and
// datapath select encodings.
package riscv_ctrl_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_OPIMM,
        CLS_OP,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } instr_class_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_BRCMP = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier for the control FSM.
//   opcode_i  : ir_q[6:0]
//   cls_o     : instruction class
//   illegal_o : opcode not in the supported RV32I set
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output instr_class_e     cls_o,
    output logic             illegal_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (opcode_i)
            OPC_LOAD:   cls_o = CLS_LOAD;
            OPC_STORE:  cls_o = CLS_STORE;
            OPC_BRANCH: cls_o = CLS_BRANCH;
            OPC_JAL:    cls_o = CLS_JAL;
            OPC_JALR:   cls_o = CLS_JALR;
            OPC_OPIMM:  cls_o = CLS_OPIMM;
            OPC_OP:     cls_o = CLS_OP;
            OPC_LUI:    cls_o = CLS_LUI;
            OPC_AUIPC:  cls_o = CLS_AUIPC;
            default:    cls_o = CLS_ILLEGAL;
        endcase
        illegal_o = (cls_o == CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch into ir_q, then step through
// DECODE/EXEC/MEM/WB driving datapath selects and strobes; counts retired
// instructions and halts permanently on an illegal opcode.
//   clk, reset                   : clock, async active-high reset
//   imem_req/ready/rdata         : instruction fetch handshake
//   dmem_req/we/ready            : data access handshake
//   branch_taken                 : ALU compare result, used in EXEC
//   ir_q                         : instruction register
//   ir_we, pc_we, pc_sel         : IR / PC update controls
//   alu_src_a, alu_src_b, alu_op : ALU operand and operation selects
//   rf_we, wb_sel                : register-file write controls
//   halted                       : illegal opcode seen
//   instret                      : retired-instruction count
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    input  logic                 branch_taken,
    output logic [31:0]          ir_q,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [1:0]           alu_src_a,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    state_e                state_q, state_d;
    logic [31:0]           ir_d;
    logic [INSTRET_W-1:0]  instret_q, instret_d;
    instr_class_e          cls;
    logic                  illegal;
    logic                  retire;

    ctrl_decode u_decode (
        .opcode_i  (ir_q[OPC_W-1:0]),
        .cls_o     (cls),
        .illegal_o (illegal)
    );

    // Next state and control outputs; outputs are forced low while reset is
    // asserted so requests drop without waiting for a clock edge.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        halted    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_PLUS4;
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_OP: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_OP_FUNCT;
                    end
                    CLS_OPIMM: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_OP_FUNCT;
                    end
                    CLS_LUI: begin
                        alu_src_a = SRC_A_ZERO;
                        alu_src_b = SRC_B_IMM;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = SRC_A_PC;
                        alu_src_b = SRC_B_IMM;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_IMM;
                    end
                    CLS_BRANCH: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_OP_BRCMP;
                        pc_we     = branch_taken;
                        pc_sel    = PC_SEL_BRANCH;
                    end
                    CLS_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_BRANCH;
                    end
                    CLS_JALR: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_JALR;
                    end
                    default: ;
                endcase
                if (cls == CLS_LOAD || cls == CLS_STORE) begin
                    state_d = ST_MEM;
                end else if (cls == CLS_BRANCH) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CLS_STORE);
                if (dmem_ready) begin
                    if (cls == CLS_STORE) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
                if (cls == CLS_LOAD) begin
                    wb_sel = WB_SEL_LOAD;
                end else if (cls == CLS_JAL || cls == CLS_JALR) begin
                    wb_sel = WB_SEL_PC4;
                end
            end
            ST_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (reset) begin
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = PC_SEL_PLUS4;
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_ADD;
            rf_we     = 1'b0;
            wb_sel    = WB_SEL_ALU;
            halted    = 1'b0;
        end
    end

    assign instret_d = retire ? (instret_q + INSTRET_W'(1)) : instret_q;
    assign instret   = instret_q;

    // State, instruction register and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= NOP_INSTR;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each instruction is expanded into its
// cycle-by-cycle phase list; expected controls come from a per-phase table.
// A second instance with a 2-bit retire counter exercises counter wrap.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       halted;
    } ctl_t;

    typedef enum {P_RESET, P_FWAIT, P_FETCH, P_DEC, P_EXEC, P_MWAIT, P_MEM, P_WB, P_TRAP} phase_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready, dmem_ready, branch_taken;
    logic [31:0] imem_rdata;

    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_b, rf_we, halted;
    logic [1:0]  pc_sel, alu_src_a, alu_op, wb_sel;
    logic [31:0] ir_q, instret;

    logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_alu_src_b, w_rf_we, w_halted;
    logic [1:0]  w_pc_sel, w_alu_src_a, w_alu_op, w_wb_sel;
    logic [31:0] w_ir_q;
    logic [1:0]  w_instret;

    ctl_t        act_ctl, w_act_ctl, exp_ctl_v;
    logic        exp_valid = 1'b0;
    logic [31:0] model_ir;
    logic [31:0] model_cnt;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .ir_q(ir_q), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .instret(instret)
    );

    multicycle_ctrl #(.INSTRET_W(2)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .ir_q(w_ir_q), .ir_we(w_ir_we), .pc_we(w_pc_we),
        .pc_sel(w_pc_sel), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
        .rf_we(w_rf_we), .wb_sel(w_wb_sel), .halted(w_halted), .instret(w_instret)
    );

    assign act_ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_a,
                      alu_src_b, alu_op, rf_we, wb_sel, halted};
    assign w_act_ctl = {w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_pc_sel, w_alu_src_a,
                        w_alu_src_b, w_alu_op, w_rf_we, w_wb_sel, w_halted};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected controls for one cycle, straight from the per-phase rules.
    function automatic ctl_t exp_ctl(input phase_e ph, input logic [6:0] opc, input logic taken);
        ctl_t e = '0;
        case (ph)
            P_FWAIT: e.imem_req = 1'b1;
            P_FETCH: begin e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; end
            P_EXEC: begin
                case (opc)
                    7'b0110011: begin e.alu_op = 2'd2; end
                    7'b0010011: begin e.alu_src_b = 1'b1; e.alu_op = 2'd2; end
                    7'b0110111: begin e.alu_src_a = 2'd2; e.alu_src_b = 1'b1; end
                    7'b0010111: begin e.alu_src_a = 2'd1; e.alu_src_b = 1'b1; end
                    7'b0000011, 7'b0100011: e.alu_src_b = 1'b1;
                    7'b1100011: begin e.alu_op = 2'd1; e.pc_we = taken; e.pc_sel = 2'd1; end
                    7'b1101111: begin e.pc_we = 1'b1; e.pc_sel = 2'd1; end
                    7'b1100111: begin e.pc_we = 1'b1; e.pc_sel = 2'd2; end
                    default: ;
                endcase
            end
            P_MWAIT, P_MEM: begin e.dmem_req = 1'b1; e.dmem_we = (opc == 7'b0100011); end
            P_WB: begin
                e.rf_we = 1'b1;
                if (opc == 7'b0000011) e.wb_sel = 2'd1;
                else if (opc == 7'b1101111 || opc == 7'b1100111) e.wb_sel = 2'd2;
            end
            P_TRAP: e.halted = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("ctl", 64'(act_ctl), 64'(exp_ctl_v));
            chk("ir_q", 64'(ir_q), 64'(model_ir));
            chk("instret", 64'(instret), 64'(model_cnt));
            chk("w_ctl", 64'(w_act_ctl), 64'(exp_ctl_v));
            chk("w_ir_q", 64'(w_ir_q), 64'(model_ir));
            chk("w_instret", 64'(w_instret), 64'(model_cnt[1:0]));
        end
    end

    // One clock of stimulus; don't-care inputs are scrambled afterwards.
    task automatic step(input phase_e ph, input bit retire);
        exp_ctl_v = exp_ctl(ph, model_ir[6:0], branch_taken);
        exp_valid = 1'b1;
        @(posedge clk);
        if (ph == P_FETCH) model_ir = imem_rdata;
        if (retire) model_cnt = model_cnt + 32'd1;
        #1;
        imem_ready   = 1'($urandom);
        imem_rdata   = $urandom;
        dmem_ready   = 1'($urandom);
        branch_taken = 1'($urandom);
        cyc++;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                             input bit taken, output int ncyc);
        logic [6:0] opc;
        bit legal;
        int start;
        start = cyc;
        opc = instr[6:0];
        legal = (opc == 7'b0000011) || (opc == 7'b0100011) || (opc == 7'b1100011) ||
                (opc == 7'b1101111) || (opc == 7'b1100111) || (opc == 7'b0010011) ||
                (opc == 7'b0110011) || (opc == 7'b0110111) || (opc == 7'b0010111);
        for (int i = 0; i < fwait; i++) begin
            imem_ready = 1'b0;
            step(P_FWAIT, 1'b0);
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        step(P_FETCH, 1'b0);
        step(P_DEC, 1'b0);
        if (legal) begin
            branch_taken = taken;
            step(P_EXEC, opc == 7'b1100011);
            if (opc == 7'b0000011 || opc == 7'b0100011) begin
                for (int i = 0; i < mwait; i++) begin
                    dmem_ready = 1'b0;
                    step(P_MWAIT, 1'b0);
                end
                dmem_ready = 1'b1;
                step(P_MEM, opc == 7'b0100011);
            end
            if (opc != 7'b1100011 && opc != 7'b0100011) step(P_WB, 1'b1);
        end
        ncyc = cyc - start;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; branch_taken = 1'b0;
        model_ir = NOP;
        model_cnt = '0;
        step(P_RESET, 1'b0);
        step(P_RESET, 1'b0);
        reset = 1'b0;

        run_instr(32'h0050_0093, 0, 0, 1'b0, n); chk("addi_cycles", 64'(n), 64'd4);
        run_instr(32'h0010_8133, 0, 0, 1'b0, n); chk("add_cycles", 64'(n), 64'd4);
        chk("instret_after_alu", 64'(instret), 64'd2);

        run_instr(32'h0040_A183, 3, 2, 1'b0, n); chk("lw_wait_cycles", 64'(n), 64'd10);
        chk("instret_after_lw", 64'(instret), 64'd3);

        run_instr(32'h0000_0463, 0, 0, 1'b1, n); chk("beq_taken_cycles", 64'(n), 64'd3);
        chk("instret_after_beq", 64'(instret), 64'd4);
        chk("w_instret_wrap", 64'(w_instret), 64'd0);
        run_instr(32'h0000_0463, 0, 0, 1'b0, n); chk("beq_nt_cycles", 64'(n), 64'd3);

        run_instr(32'h0002_80E7, 0, 0, 1'b0, n); chk("jalr_cycles", 64'(n), 64'd4);
        run_instr(32'h0020_A023, 0, 1, 1'b0, n); chk("sw_cycles", 64'(n), 64'd5);
        run_instr(32'h0020_A023, 0, 0, 1'b0, n); chk("sw_zw_cycles", 64'(n), 64'd4);
        run_instr(32'h1234_50B7, 0, 0, 1'b0, n); chk("lui_cycles", 64'(n), 64'd4);
        run_instr(32'h0000_0117, 0, 0, 1'b0, n); chk("auipc_cycles", 64'(n), 64'd4);
        run_instr(32'h0080_00EF, 0, 0, 1'b0, n); chk("jal_cycles", 64'(n), 64'd4);
        chk("instret_after_mix", 64'(instret), 64'd11);

        // Load stalled in MEM, then reset mid-access.
        imem_ready = 1'b1; imem_rdata = 32'h0040_A183;
        step(P_FETCH, 1'b0);
        step(P_DEC, 1'b0);
        step(P_EXEC, 1'b0);
        dmem_ready = 1'b0; step(P_MWAIT, 1'b0);
        dmem_ready = 1'b0;
        reset = 1'b1;
        model_ir = NOP;
        model_cnt = '0;
        #1;
        chk("reset_drops_dmem_req", 64'(dmem_req), 64'd0);
        chk("reset_ir_nop", 64'(ir_q), 64'(NOP));
        step(P_RESET, 1'b0);
        step(P_RESET, 1'b0);
        reset = 1'b0;
        imem_ready = 1'b0;
        step(P_FWAIT, 1'b0);

        run_instr(32'h0050_0093, 0, 0, 1'b0, n); chk("addi2_cycles", 64'(n), 64'd4);

        // Illegal opcode: halt, no further fetch, count frozen.
        run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, n); chk("illegal_cycles", 64'(n), 64'd2);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1;
            step(P_TRAP, 1'b0);
        end
        chk("halted_sticky", 64'(halted), 64'd1);
        chk("instret_after_trap", 64'(instret), 64'd1);

        reset = 1'b1;
        model_ir = NOP;
        model_cnt = '0;
        step(P_RESET, 1'b0);
        reset = 1'b0;
        imem_ready = 1'b0;
        step(P_FWAIT, 1'b0);
        chk("halted_cleared", 64'(halted), 64'd0);

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
